// File: rtl/mf8_pkg.sv
// Shared types and helpers for the mf8 register file.
//   mf8_rf_state_e : register-file controller state (clear after reset, then run)
//   mf8_ptr_base   : base (low-byte, even) address of the X/Y/Z pointer pairs
package mf8_pkg;

  typedef enum logic {
    MF8_RF_CLEAR = 1'b0,
    MF8_RF_RUN   = 1'b1
  } mf8_rf_state_e;

  localparam int unsigned MF8_PTR_X = 0;
  localparam int unsigned MF8_PTR_Y = 1;
  localparam int unsigned MF8_PTR_Z = 2;

  // X, Y, Z occupy the top six registers: 2**aw-6, 2**aw-4, 2**aw-2.
  function automatic int unsigned mf8_ptr_base(input int unsigned aw, input int unsigned ptr);
    return (32'd1 << aw) - 32'd6 + 32'd2 * ptr;
  endfunction

endpackage

// File: rtl/mf8_reg_bank.sv
// One bank (even or odd addresses) of the mf8 register file.
// Storage has no reset; the owner clears it by writing.
//   clk_i                 clock
//   we_i/waddr_i/wdata_i  single write port
//   ra/rb/rc_addr_i       three synchronous read addresses
//   ra/rb/rc_data_o       read data, one cycle after the address (old data on a same-edge write)
module mf8_reg_bank #(
  parameter int unsigned Dw = 8,
  parameter int unsigned Aw = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [Dw-1:0] wdata_i,
  input  logic [Aw-1:0] ra_addr_i,
  input  logic [Aw-1:0] rb_addr_i,
  input  logic [Aw-1:0] rc_addr_i,
  output logic [Dw-1:0] ra_data_o,
  output logic [Dw-1:0] rb_data_o,
  output logic [Dw-1:0] rc_data_o
);

  logic [Dw-1:0] mem_q [2**Aw];
  logic [Dw-1:0] ra_q, rb_q, rc_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    ra_q <= mem_q[ra_addr_i];
    rb_q <= mem_q[rb_addr_i];
    rc_q <= mem_q[rc_addr_i];
  end

  assign ra_data_o = ra_q;
  assign rb_data_o = rb_q;
  assign rc_data_o = rc_q;

endmodule

// File: rtl/mf8_regfile_w.sv
// mf8 CPU register file: two byte read ports, one register-pair read port, byte and
// pair write-back, same-edge write-through on every read, and live X/Y/Z pointer mirrors.
// After reset the array is cleared one pair per cycle while Busy is high.
//   Clk, Reset_n         clock, asynchronous active-low reset
//   Busy                 high while the post-reset clear runs
//   Wr, Wr_Word          byte / pair write to the previous cycle's Rd_Addr (pair wins)
//   Rd_Addr, Rr_Addr     read addresses (Rd_Addr also becomes next cycle's write address)
//   Data_In, Data_In_Hi  write data (low / high byte)
//   Rd_Data, Rr_Data     byte reads, Rd_Word pair read at Rd_Addr, all 1-cycle latency
//   X, Y, Z              pointer pairs at the top six registers
module mf8_regfile_w
  import mf8_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic          Clk,
  input  logic          Reset_n,
  output logic          Busy,
  input  logic          Wr,
  input  logic          Wr_Word,
  input  logic [AW-1:0] Rd_Addr,
  input  logic [AW-1:0] Rr_Addr,
  input  logic [DW-1:0] Data_In,
  input  logic [DW-1:0] Data_In_Hi,
  output logic [DW-1:0] Rd_Data,
  output logic [DW-1:0] Rr_Data,
  output logic [2*DW-1:0] Rd_Word,
  output logic [2*DW-1:0] X,
  output logic [2*DW-1:0] Y,
  output logic [2*DW-1:0] Z
);

  localparam int unsigned PW = AW - 1;
  localparam logic [PW-1:0] LastPair = '1;
  localparam int unsigned XPair = mf8_ptr_base(AW, MF8_PTR_X) / 2;

  mf8_rf_state_e state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wa_q;

  // Bank write controls
  logic          even_we, odd_we;
  logic [PW-1:0] wpair;
  logic [DW-1:0] even_wdata, odd_wdata;

  logic [DW-1:0] even_ra, even_rb, even_rc, odd_ra, odd_rb, odd_rc;

  // Read capture: address LSB plus a per-byte write-through override
  logic          out_en_q, out_en_d;
  logic          rd_lsb_q, rd_hit_q, rr_lsb_q, rr_hit_q, wl_hit_q, wh_hit_q;
  logic          rd_hit_d, rr_hit_d, wl_hit_d, wh_hit_d;
  logic [DW-1:0] rd_hdata_q, rr_hdata_q, wl_hdata_q, wh_hdata_q;
  logic [DW-1:0] rd_hdata_d, rr_hdata_d;

  logic [5:0][DW-1:0] ptr_q, ptr_d;

  assign Busy = (state_q == MF8_RF_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MF8_RF_CLEAR: begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == LastPair) begin
          state_d = MF8_RF_RUN;
        end
      end
      MF8_RF_RUN: begin
        state_d = MF8_RF_RUN;
      end
    endcase
  end

  // Write steering: clear writes both banks; a pair write ignores Wa[0].
  always_comb begin
    even_we    = 1'b0;
    odd_we     = 1'b0;
    wpair      = wa_q[AW-1:1];
    even_wdata = Data_In;
    odd_wdata  = Data_In;
    if (state_q == MF8_RF_CLEAR) begin
      even_we    = 1'b1;
      odd_we     = 1'b1;
      wpair      = cnt_q;
      even_wdata = '0;
      odd_wdata  = '0;
    end else if (Wr_Word) begin
      even_we   = 1'b1;
      odd_we    = 1'b1;
      odd_wdata = Data_In_Hi;
    end else if (Wr) begin
      even_we = ~wa_q[0];
      odd_we  = wa_q[0];
    end
  end

  // Write-through detection for each read byte
  always_comb begin
    out_en_d   = (state_q == MF8_RF_RUN);
    rd_hit_d   = (Rd_Addr[0] ? odd_we : even_we) && (Rd_Addr[AW-1:1] == wpair);
    rd_hdata_d = Rd_Addr[0] ? odd_wdata : even_wdata;
    rr_hit_d   = (Rr_Addr[0] ? odd_we : even_we) && (Rr_Addr[AW-1:1] == wpair);
    rr_hdata_d = Rr_Addr[0] ? odd_wdata : even_wdata;
    wl_hit_d   = even_we && (Rd_Addr[AW-1:1] == wpair);
    wh_hit_d   = odd_we && (Rd_Addr[AW-1:1] == wpair);
  end

  // Pointer mirrors follow any write to their byte; forced to zero while clearing.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < 6; i++) begin
      if (state_q == MF8_RF_CLEAR) begin
        ptr_d[i] = '0;
      end else if (i % 2 == 0) begin
        if (even_we && (wpair == PW'(XPair + i / 2))) ptr_d[i] = even_wdata;
      end else begin
        if (odd_we && (wpair == PW'(XPair + i / 2))) ptr_d[i] = odd_wdata;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= MF8_RF_CLEAR;
      cnt_q      <= '0;
      wa_q       <= '0;
      out_en_q   <= 1'b0;
      rd_lsb_q   <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_hdata_q <= '0;
      rr_lsb_q   <= 1'b0;
      rr_hit_q   <= 1'b0;
      rr_hdata_q <= '0;
      wl_hit_q   <= 1'b0;
      wl_hdata_q <= '0;
      wh_hit_q   <= 1'b0;
      wh_hdata_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wa_q       <= Rd_Addr;
      out_en_q   <= out_en_d;
      rd_lsb_q   <= Rd_Addr[0];
      rd_hit_q   <= rd_hit_d;
      rd_hdata_q <= rd_hdata_d;
      rr_lsb_q   <= Rr_Addr[0];
      rr_hit_q   <= rr_hit_d;
      rr_hdata_q <= rr_hdata_d;
      wl_hit_q   <= wl_hit_d;
      wl_hdata_q <= even_wdata;
      wh_hit_q   <= wh_hit_d;
      wh_hdata_q <= odd_wdata;
      ptr_q      <= ptr_d;
    end
  end

  mf8_reg_bank #(.Dw(DW), .Aw(PW)) u_even (
    .clk_i     (Clk),
    .we_i      (even_we),
    .waddr_i   (wpair),
    .wdata_i   (even_wdata),
    .ra_addr_i (Rd_Addr[AW-1:1]),
    .rb_addr_i (Rr_Addr[AW-1:1]),
    .rc_addr_i (Rd_Addr[AW-1:1]),
    .ra_data_o (even_ra),
    .rb_data_o (even_rb),
    .rc_data_o (even_rc)
  );

  mf8_reg_bank #(.Dw(DW), .Aw(PW)) u_odd (
    .clk_i     (Clk),
    .we_i      (odd_we),
    .waddr_i   (wpair),
    .wdata_i   (odd_wdata),
    .ra_addr_i (Rd_Addr[AW-1:1]),
    .rb_addr_i (Rr_Addr[AW-1:1]),
    .rc_addr_i (Rd_Addr[AW-1:1]),
    .ra_data_o (odd_ra),
    .rb_data_o (odd_rb),
    .rc_data_o (odd_rc)
  );

  // Reads captured while clearing (including the final clear edge) present zero.
  always_comb begin
    Rd_Data = '0;
    Rr_Data = '0;
    Rd_Word = '0;
    if (out_en_q) begin
      Rd_Data = rd_hit_q ? rd_hdata_q : (rd_lsb_q ? odd_ra : even_ra);
      Rr_Data = rr_hit_q ? rr_hdata_q : (rr_lsb_q ? odd_rb : even_rb);
      Rd_Word = {(wh_hit_q ? wh_hdata_q : odd_rc), (wl_hit_q ? wl_hdata_q : even_rc)};
    end
  end

  assign X = {ptr_q[1], ptr_q[0]};
  assign Y = {ptr_q[3], ptr_q[2]};
  assign Z = {ptr_q[5], ptr_q[4]};

endmodule
